hyper_mvblck_todram_sched: RTL and testbench

HYPER_MVBLCK_TODRAM_SCHED -- requirements
Module: hyper_mvblck_todram_sched

---
 rtl/hyper_mvblck_todram_sched.sv | 154 +++++++++++++++
 tb/tb_hyper_mvblck_todram_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_mvblck_todram_sched.sv
// Round-robin scheduler handing LSAB section descriptors to the DRAM block mover.
// Grant -> ISSUE in one cycle; the mover paces via WORKING, with WAIT_START guarded by an 8-cycle watchdog.
module hyper_mvblck_todram_sched (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] REQ,
   input  logic       CFG_WE,
   input  logic [1:0] CFG_SEC,
   input  logic [8:0] CFG_ADDR,
   input  logic [5:0] CFG_COUNT,
   input  logic [1:0] CFG_DRAM,
   output logic       ISSUE,
   output logic [8:0] START_ADDRESS,
   output logic [5:0] COUNT_REQ,
   output logic [1:0] SECTION,
   output logic [1:0] DRAM_SEL,
   input  logic       WORKING,
   input  logic [5:0] COUNT_SENT,
   input  logic       IRQ_OUT,
   input  logic       ABRUPT_STOP,
   output logic       BUSY,
   output logic       DONE,
   output logic [1:0] DONE_SEC,
   output logic [5:0] DONE_COUNT,
   output logic       DONE_IRQ,
   output logic       DONE_ABRUPT,
   output logic       ERR,
   output logic [3:0] ARMED
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ISSUE      = 3'd1;
   localparam logic [2:0] S_WAIT_START = 3'd2;
   localparam logic [2:0] S_WAIT_DONE  = 3'd3;
   localparam logic [2:0] S_REPORT     = 3'd4;

   logic [2:0] state;
   logic [8:0] addr [4];
   logic [5:0] cnt  [4];
   logic [1:0] dram [4];
   logic [3:0] armed;
   logic [1:0] last_gnt;
   logic [1:0] cur_sec;
   logic [8:0] cur_addr;
   logic [5:0] cur_cnt;
   logic [1:0] cur_dram;
   logic [2:0] wdog;
   logic       err_pulse;
   logic [3:0] elig;
   logic       gnt_vld;
   logic [1:0] gnt_sec;
   logic [1:0] rr_idx;

   assign elig = armed & REQ;

   // Scan from last_gnt+4 down to last_gnt+1 so the closest successor wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_sec = last_gnt;
      rr_idx  = last_gnt;
      for (int i = 4; i >= 1; i--) begin
         rr_idx = last_gnt + 2'(i);
         if (elig[rr_idx]) begin
            gnt_vld = 1'b1;
            gnt_sec = rr_idx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= S_IDLE;
         last_gnt  <= 2'd3;
         cur_sec   <= 2'd0;
         cur_addr  <= 9'd0;
         cur_cnt   <= 6'd0;
         cur_dram  <= 2'd0;
         wdog      <= 3'd0;
         err_pulse <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt_vld) begin
                  state    <= S_ISSUE;
                  last_gnt <= gnt_sec;
                  cur_sec  <= gnt_sec;
                  cur_addr <= addr[gnt_sec];
                  cur_cnt  <= cnt[gnt_sec];
                  cur_dram <= dram[gnt_sec];
               end
            end
            S_ISSUE: begin
               state <= S_WAIT_START;
               wdog  <= 3'd0;
            end
            S_WAIT_START: begin
               if (WORKING) begin
                  state <= S_WAIT_DONE;
               end else if (wdog == 3'd7) begin
                  state     <= S_IDLE;
                  err_pulse <= 1'b1;
               end else begin
                  wdog <= wdog + 3'd1;
               end
            end
            S_WAIT_DONE: begin
               if (!WORKING) state <= S_REPORT;
            end
            S_REPORT: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // A config write to the section being reported overrides the completion update entirely.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int n = 0; n < 4; n++) begin
            addr[n] <= 9'd0;
            cnt[n]  <= 6'd0;
            dram[n] <= 2'd0;
         end
         armed <= 4'd0;
      end else begin
         for (int n = 0; n < 4; n++) begin
            if (CFG_WE && CFG_SEC == 2'(n)) begin
               addr[n]  <= CFG_ADDR;
               cnt[n]   <= CFG_COUNT;
               dram[n]  <= CFG_DRAM;
               armed[n] <= (CFG_COUNT != 6'd0);
            end else if (state == S_REPORT && cur_sec == 2'(n)) begin
               addr[n] <= addr[n] + {3'b000, COUNT_SENT};
               if (IRQ_OUT) armed[n] <= 1'b0;
            end
         end
      end
   end

   assign ISSUE         = (state == S_ISSUE);
   assign BUSY          = (state != S_IDLE);
   assign START_ADDRESS = cur_addr;
   assign COUNT_REQ     = cur_cnt;
   assign SECTION       = cur_sec;
   assign DRAM_SEL      = cur_dram;
   assign DONE          = (state == S_REPORT);
   assign DONE_SEC      = DONE ? cur_sec : 2'd0;
   assign DONE_COUNT    = DONE ? COUNT_SENT : 6'd0;
   assign DONE_IRQ      = DONE & IRQ_OUT;
   assign DONE_ABRUPT   = DONE & ABRUPT_STOP;
   assign ERR           = err_pulse;
   assign ARMED         = armed;

endmodule

// File: tb/tb_hyper_mvblck_todram_sched.sv
// Randomized scoreboard bench: driver acts as the block mover, monitor checks every ISSUE/DONE/ERR.
module tb_hyper_mvblck_todram_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] req = 4'd0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_sec = 2'd0;
   logic [8:0] cfg_addr = 9'd0;
   logic [5:0] cfg_count = 6'd0;
   logic [1:0] cfg_dram = 2'd0;
   logic       working = 1'b0;
   logic [5:0] count_sent = 6'd0;
   logic       irq_out = 1'b0;
   logic       abrupt_stop = 1'b0;
   logic       issue, busy, done, done_irq, done_abrupt, err;
   logic [8:0] start_address;
   logic [5:0] count_req, done_count;
   logic [1:0] section, dram_sel, done_sec;
   logic [3:0] armed;

   hyper_mvblck_todram_sched dut (
      .CLK(clk), .RST(rst), .REQ(req),
      .CFG_WE(cfg_we), .CFG_SEC(cfg_sec), .CFG_ADDR(cfg_addr), .CFG_COUNT(cfg_count), .CFG_DRAM(cfg_dram),
      .ISSUE(issue), .START_ADDRESS(start_address), .COUNT_REQ(count_req), .SECTION(section), .DRAM_SEL(dram_sel),
      .WORKING(working), .COUNT_SENT(count_sent), .IRQ_OUT(irq_out), .ABRUPT_STOP(abrupt_stop),
      .BUSY(busy), .DONE(done), .DONE_SEC(done_sec), .DONE_COUNT(done_count), .DONE_IRQ(done_irq),
      .DONE_ABRUPT(done_abrupt), .ERR(err), .ARMED(armed)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] sec;
      logic [8:0] addr;
      logic [5:0] cnt;
      logic [1:0] dram;
   } iss_t;

   typedef struct packed {
      logic [1:0] sec;
      logic [5:0] cnt;
      logic       irq;
      logic       abr;
   } dn_t;

   iss_t iss_q[$];
   dn_t  dn_q[$];
   bit   err_q[$];

   // Reference model of the per-section descriptor table.
   logic [8:0] m_addr [4];
   logic [5:0] m_cnt  [4];
   logic [1:0] m_dram [4];
   logic [3:0] m_armed;
   int         m_last;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         m_addr[n] = 9'd0;
         m_cnt[n]  = 6'd0;
         m_dram[n] = 2'd0;
      end
      m_armed = 4'd0;
      m_last  = 3;
   endtask

   function automatic int pick(input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         int s;
         s = (m_last + k) % 4;
         if (m_armed[s] && r[s]) return s;
      end
      return -1;
   endfunction

   task automatic do_cfg(input int s, input logic [8:0] a, input logic [5:0] c, input logic [1:0] d);
      cfg_we = 1'b1; cfg_sec = 2'(s); cfg_addr = a; cfg_count = c; cfg_dram = d;
      @(negedge clk);
      cfg_we = 1'b0;
      m_addr[s] = a; m_cnt[s] = c; m_dram[s] = d; m_armed[s] = (c != 6'd0);
   endtask

   // Called at a falling edge while the scheduler is idle.
   task automatic xfer(input logic [3:0] reqp, input bit hold, input int work,
                       input logic [5:0] sent, input logic irq, input logic abr,
                       input bit tmo, input bit col,
                       input logic [8:0] ca, input logic [5:0] cc, input logic [1:0] cd);
      int s, n;
      s = pick(reqp);
      if (s < 0) begin
         req = 4'd0;
         return;
      end
      iss_q.push_back(iss_t'{sec: 2'(s), addr: m_addr[s], cnt: m_cnt[s], dram: m_dram[s]});
      m_last = s;
      req = reqp;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!issue && n < 12);
      if (!issue) begin
         total++; bad++;
         $display("FAIL issue_timeout: no ISSUE after %0d cycles, want section %0d", n, s);
         req = 4'd0;
         iss_q.delete();
         return;
      end
      if (!hold) req = 4'd0;
      if (tmo) begin
         err_q.push_back(1'b1);
         repeat (9) @(negedge clk);
         chk("err_pulse", err, 1);
         chk("err_idle", busy, 0);
         return;
      end
      working = 1'b1;
      repeat (work) @(negedge clk);
      working = 1'b0; count_sent = sent; irq_out = irq; abrupt_stop = abr;
      dn_q.push_back(dn_t'{sec: 2'(s), cnt: sent, irq: irq, abr: abr});
      if (col) begin
         m_addr[s] = ca; m_cnt[s] = cc; m_dram[s] = cd; m_armed[s] = (cc != 6'd0);
      end else begin
         m_addr[s] = m_addr[s] + 9'(sent);
         if (irq) m_armed[s] = 1'b0;
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      if (col) begin
         cfg_we = 1'b1; cfg_sec = 2'(s); cfg_addr = ca; cfg_count = cc; cfg_dram = cd;
      end
      @(negedge clk);
      cfg_we = 1'b0; count_sent = 6'd0; irq_out = 1'b0; abrupt_stop = 1'b0;
      chk("armed_after", armed, m_armed);
   endtask

   // Monitor: pops expectations whenever the DUT presents ISSUE, DONE or ERR.
   initial begin
      iss_t cur;
      dn_t  de;
      bit   have_cur;
      int   cyc, last_iss;
      have_cur = 1'b0; cyc = 0; last_iss = -1000;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            if (issue) begin
               chk("issue_spacing", (cyc - last_iss) >= 4, 1);
               last_iss = cyc;
               if (iss_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL issue_unexpected: section %0d issued, none expected", section);
               end else begin
                  cur = iss_q.pop_front();
                  have_cur = 1'b1;
                  chk("issue_sec", section, cur.sec);
                  chk("issue_addr", start_address, cur.addr);
                  chk("issue_cnt", count_req, cur.cnt);
                  chk("issue_dram", dram_sel, cur.dram);
                  chk("issue_busy", busy, 1);
               end
            end else if (busy && have_cur) begin
               chk("hold_outputs", {start_address, count_req, section, dram_sel},
                   {cur.addr, cur.cnt, cur.sec, cur.dram});
            end
            if (done) begin
               if (dn_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL done_unexpected: DONE for section %0d, none expected", done_sec);
               end else begin
                  de = dn_q.pop_front();
                  chk("done_sec", done_sec, de.sec);
                  chk("done_count", done_count, de.cnt);
                  chk("done_irq", done_irq, de.irq);
                  chk("done_abrupt", done_abrupt, de.abr);
               end
            end
            if (err) begin
               if (err_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL err_unexpected: ERR pulsed, none expected");
               end else begin
                  void'(err_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int s;
      logic [3:0] r;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_issue", issue, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_armed", armed, 0);
      chk("rst_mover", {start_address, count_req, section, dram_sel}, 0);
      chk("rst_done_fields", {done_sec, done_count, done_irq, done_abrupt}, 0);
      rst = 1'b1;
      @(negedge clk);

      // All four armed, REQ held high: round-robin 0,1,2,3,0.
      for (int n = 0; n < 4; n++) do_cfg(n, 9'(16 * n), 6'(n + 1), 2'(n));
      chk("armed_all", armed, 4'b1111);
      for (int k = 0; k < 5; k++) xfer(4'b1111, k < 4, 2, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      // Basic transfer on section 1, then a follow-up at the advanced pointer.
      do_cfg(1, 9'h010, 6'd8, 2'd2);
      xfer(4'b0010, 0, 3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);
      chk("armed_sec1", armed[1], 1);
      xfer(4'b0010, 0, 2, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);
      xfer(4'b0010, 0, 2, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      // Pointer wrap at 512.
      do_cfg(0, 9'h1FC, 6'd6, 2'd1);
      xfer(4'b0001, 0, 4, 6'd6, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);
      xfer(4'b0001, 0, 2, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      // IRQ + abrupt stop disarms section 2; it is then skipped.
      do_cfg(2, 9'h0A0, 6'd9, 2'd3);
      xfer(4'b0100, 0, 3, 6'd3, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);
      chk("armed_sec2_clr", armed[2], 0);
      xfer(4'b0110, 0, 2, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      // Mover never starts: watchdog error, descriptor untouched.
      do_cfg(3, 9'h155, 6'd12, 2'd2);
      xfer(4'b1000, 0, 2, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 6'd0, 2'd0);
      xfer(4'b1000, 0, 2, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      // Config write lands in the same cycle as the report.
      xfer(4'b0010, 0, 3, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 9'h123, 6'd7, 2'd3);
      xfer(4'b0010, 0, 2, 6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      for (int it = 0; it < 30; it++) begin
         bit tmo, col;
         r = 4'($urandom_range(1, 15));
         if ((m_armed & r) == 4'd0) begin
            s = 0;
            while (!r[s]) s++;
            do_cfg(s, 9'($urandom), 6'($urandom_range(1, 63)), 2'($urandom));
         end
         tmo = ($urandom_range(0, 7) == 0);
         col = !tmo && ($urandom_range(0, 5) == 0);
         xfer(r, 0, $urandom_range(2, 5), 6'($urandom), $urandom_range(0, 3) == 0,
              1'($urandom), tmo, col, 9'($urandom), 6'($urandom), 2'($urandom));
      end

      // Reset while waiting for the mover to finish.
      do_cfg(2, 9'h044, 6'd20, 2'd1);
      s = pick(4'b0100);
      iss_q.push_back(iss_t'{sec: 2'(s), addr: m_addr[s], cnt: m_cnt[s], dram: m_dram[s]});
      req = 4'b0100;
      for (int n = 0; n < 12 && !issue; n++) @(negedge clk);
      chk("midrst_issue_seen", issue, 1);
      req = 4'd0;
      working = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_busy_before", busy, 1);
      rst = 1'b0;
      working = 1'b0;
      model_reset();
      iss_q.delete();
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_armed", armed, 0);
      chk("midrst_done", done, 0);
      chk("midrst_mover", {issue, start_address, count_req, section, dram_sel}, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // After reset the arbiter restarts from section 0.
      do_cfg(0, 9'h0F0, 6'd3, 2'd2);
      do_cfg(3, 9'h030, 6'd4, 2'd1);
      xfer(4'b1001, 0, 2, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);
      xfer(4'b1001, 0, 2, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 6'd0, 2'd0);

      repeat (3) @(negedge clk);
      chk("iss_q_empty", iss_q.size(), 0);
      chk("dn_q_empty", dn_q.size(), 0);
      chk("err_q_empty", err_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
